// File: rtl/apu_sfx_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apu_sfx_scheduler_pkg                                           |
// | Purpose  : Shared sound-effect ids, scheduler state encoding, default      |
// |            frame durations and the fixed-priority pick helper.             |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package apu_sfx_scheduler_pkg;

  // Sound ids double as priority values: a numerically larger id wins.
  typedef logic [1:0] sfx_id_t;
  localparam sfx_id_t SFX_NONE = 2'b00;
  localparam sfx_id_t SFX_EAT  = 2'b01;
  localparam sfx_id_t SFX_HIT  = 2'b10;
  localparam sfx_id_t SFX_DIE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_t;

  // Default durations in video frames; the APU trigger wrapper and the
  // bench both take their timing from here.
  localparam int DEF_EAT_FRAMES = 8;
  localparam int DEF_HIT_FRAMES = 6;
  localparam int DEF_DIE_FRAMES = 30;
  localparam int DEF_GAP_FRAMES = 2;
  localparam int DEF_CNT_W      = 6;

  // pend bit 0 = eat, bit 1 = hit, bit 2 = die.
  function automatic sfx_id_t sfx_highest(input logic [2:0] pend);
    if (pend[2])      return SFX_DIE;
    else if (pend[1]) return SFX_HIT;
    else if (pend[0]) return SFX_EAT;
    else              return SFX_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apu_sfx_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apu_sfx_scheduler_if                                            |
// | Purpose  : Bundles the collision requests, frame tick and mute toward the  |
// |            scheduler, and the APU triggers / status coming back.           |
// | Ports    : master - drives frame_tick, req_*, mute; reads status           |
// |            slave  - the scheduler side (inputs/outputs reversed)           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface apu_sfx_scheduler_if;
  import apu_sfx_scheduler_pkg::*;

  logic    frame_tick;
  logic    req_eat;
  logic    req_hit;
  logic    req_die;
  logic    mute;
  logic    saw_trigger;
  logic    square_trigger;
  logic    noise_trigger;
  logic    busy;
  sfx_id_t active_id;
  logic    dropped;

  modport master (
    output frame_tick, req_eat, req_hit, req_die, mute,
    input  saw_trigger, square_trigger, noise_trigger, busy, active_id, dropped
  );

  modport slave (
    input  frame_tick, req_eat, req_hit, req_die, mute,
    output saw_trigger, square_trigger, noise_trigger, busy, active_id, dropped
  );

endinterface
`default_nettype wire

// File: rtl/apu_sfx_scheduler_req_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sfx_req_latch                                                   |
// | Purpose  : Rising-edge detect on one collision request plus its pending    |
// |            bit.                                                            |
// | Ports    : clk, rst_n   - clock, async active-low reset                    |
// |            req          - raw request (level or pulse)                     |
// |            set_en       - allow a detected edge to set pending             |
// |            clr          - clear pending (sound granted)                    |
// |            flush        - mute: clear pending and discard edges            |
// |            rise         - combinational edge strobe (already muted)        |
// |            pending      - request waiting for a grant                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sfx_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic set_en,
  input  logic clr,
  input  logic flush,
  output logic rise,
  output logic pending
);

  logic req_q;

  // req_q keeps tracking during mute so a level held across mute release
  // does not count as a new request.
  assign rise = req & ~req_q & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      req_q <= req;
      if (flush || clr)
        pending <= 1'b0;
      else if (rise && set_en)
        pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apu_sfx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apu_sfx_scheduler                                               |
// | Purpose  : Turns collision events into one-at-a-time, frame-timed APU      |
// |            trigger grants with priority die > hit > eat, preemption,       |
// |            retrigger and a post-sound silent gap.                          |
// | Ports    : clk   - pixel clock                                             |
// |            rst_n - async active-low reset                                  |
// |            bus   - slave side of apu_sfx_scheduler_if (requests, tick,     |
// |                    mute in; saw/square/noise triggers, busy, active_id,    |
// |                    dropped out)                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apu_sfx_scheduler
  import apu_sfx_scheduler_pkg::*;
#(
  parameter int EAT_FRAMES = DEF_EAT_FRAMES,
  parameter int HIT_FRAMES = DEF_HIT_FRAMES,
  parameter int DIE_FRAMES = DEF_DIE_FRAMES,
  parameter int GAP_FRAMES = DEF_GAP_FRAMES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apu_sfx_scheduler_if.slave   bus
);

  // A programmed duration of 0 still plays for one frame.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EAT_LOAD = (EAT_FRAMES == 0) ? CNT_ONE : CNT_W'(EAT_FRAMES);
  localparam logic [CNT_W-1:0] HIT_LOAD = (HIT_FRAMES == 0) ? CNT_ONE : CNT_W'(HIT_FRAMES);
  localparam logic [CNT_W-1:0] DIE_LOAD = (DIE_FRAMES == 0) ? CNT_ONE : CNT_W'(DIE_FRAMES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_FRAMES);

  function automatic logic [CNT_W-1:0] load_of(input sfx_id_t id);
    case (id)
      SFX_EAT: return EAT_LOAD;
      SFX_HIT: return HIT_LOAD;
      default: return DIE_LOAD;
    endcase
  endfunction

  sfx_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  sfx_id_t          active_id, active_nx;
  logic             dropped, dropped_nx;

  logic [2:0] req;
  logic [2:0] rise;
  logic [2:0] pend;
  logic [2:0] set_en;
  logic [2:0] clr;
  sfx_id_t    top_id;
  logic       retrig;

  assign req    = {bus.req_die, bus.req_hit, bus.req_eat};
  assign top_id = sfx_highest(pend);

  for (genvar i = 0; i < 3; i++) begin : g_req
    sfx_req_latch u_latch (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[i]),
      .set_en  (set_en[i]),
      .clr     (clr[i]),
      .flush   (bus.mute),
      .rise    (rise[i]),
      .pending (pend[i])
    );
  end

  // An edge of the sound already playing is a retrigger, not a new request.
  always_comb begin
    set_en = 3'b111;
    retrig = 1'b0;
    if (state == ST_PLAY) begin
      case (active_id)
        SFX_EAT: begin set_en[0] = 1'b0; retrig = rise[0]; end
        SFX_HIT: begin set_en[1] = 1'b0; retrig = rise[1]; end
        SFX_DIE: begin set_en[2] = 1'b0; retrig = rise[2]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      active_id <= SFX_NONE;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      active_id <= active_nx;
      dropped   <= dropped_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    active_nx  = active_id;
    dropped_nx = 1'b0;
    clr        = 3'b000;

    if (bus.mute) begin
      state_nx  = ST_IDLE;
      cnt_nx    = '0;
      active_nx = SFX_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (top_id != SFX_NONE) begin
            state_nx  = ST_PLAY;
            cnt_nx    = load_of(top_id);
            active_nx = top_id;
            clr[top_id - 2'd1] = 1'b1;
          end
        end

        ST_PLAY: begin
          // Reload paths take precedence over a coincident frame tick.
          if (top_id > active_id) begin
            cnt_nx     = load_of(top_id);
            active_nx  = top_id;
            dropped_nx = 1'b1;
            clr[top_id - 2'd1] = 1'b1;
          end else if (retrig) begin
            cnt_nx = load_of(active_id);
          end else if (bus.frame_tick) begin
            if (cnt <= CNT_ONE) begin
              active_nx = SFX_NONE;
              if (GAP_FRAMES > 0) begin
                state_nx = ST_GAP;
                cnt_nx   = GAP_LOAD;
              end else begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
              end
            end else begin
              cnt_nx = cnt - CNT_ONE;
            end
          end
        end

        ST_GAP: begin
          // Only a death sound may cut the silent gap short.
          if (pend[2]) begin
            state_nx  = ST_PLAY;
            cnt_nx    = DIE_LOAD;
            active_nx = SFX_DIE;
            clr[2]    = 1'b1;
          end else if (bus.frame_tick) begin
            if (cnt <= CNT_ONE) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt - CNT_ONE;
            end
          end
        end

        default: begin
          state_nx  = ST_IDLE;
          cnt_nx    = '0;
          active_nx = SFX_NONE;
        end
      endcase
    end
  end

  assign bus.saw_trigger    = (state == ST_PLAY) && (active_id == SFX_EAT);
  assign bus.square_trigger = (state == ST_PLAY) && (active_id == SFX_HIT);
  assign bus.noise_trigger  = (state == ST_PLAY) && (active_id == SFX_DIE);
  assign bus.busy           = (state != ST_IDLE);
  assign bus.active_id      = active_id;
  assign bus.dropped        = dropped;

endmodule
`default_nettype wire

// File: doc/apu_sfx_scheduler.md
Name: apu_sfx_scheduler

Overview:
- Sits between the collision/event logic and the AudioProcessingUnit, which has one tone generator per waveform and a single shared output.
- Turns one-cycle or level collision events into timed sound-effect grants, one at a time. Grants are ordered by fixed priority (die > hit > eat) and carry preemption, retrigger and inter-sound cooldown.
- Each grant drives exactly one of the APU's saw/square/noise triggers for a programmable number of video frames.

Parameters:
- EAT_FRAMES, 8, frames the eat sound (saw) plays.
- HIT_FRAMES, 6, frames the hit sound (square) plays.
- DIE_FRAMES, 30, frames the die sound (noise) plays.
- GAP_FRAMES, 2, silent frames forced after a sound ends naturally.
- CNT_W, 6, width of the frame countdown; all *_FRAMES must be ≤ 2^CNT_W−1.

Ports:
- clk, input, 1, system clock (25 MHz pixel clock).
- rst_n, input, 1, asynchronous active-low reset.
- frame_tick, input, 1, one-cycle pulse per video frame (sync generator frame_end).
- req_eat, input, 1, sheep–dragon collision (level or pulse).
- req_hit, input, 1, sword–dragon collision.
- req_die, input, 1, player–dragon collision.
- mute, input, 1, level; silences and flushes the block.
- saw_trigger, output, 1, high while the eat sound is granted.
- square_trigger, output, 1, high while the hit sound is granted.
- noise_trigger, output, 1, high while the die sound is granted.
- busy, output, 1, high in PLAY or GAP.
- active_id, output, 2, 00 none, 01 eat, 10 hit, 11 die.
- dropped, output, 1, one-cycle pulse when a sound is preempted.

Behaviour:
- Reset (async, rst_n=0): state IDLE; counter 0; pending[2:0] 0; edge registers 0; all outputs 0.
- Request edge detect:
  - Each req_* is registered once; a rising edge sets pending[id].
  - A level held high produces only one request.
  - Edges arriving while mute=1 are discarded.
- Priority: die(3) > hit(2) > eat(1). Ties resolve by this order.
- State IDLE:
  - If pending≠0 and mute=0, grant the highest pending id.
  - The grant clears that pending bit, loads counter with that id's *_FRAMES (a value of 0 is treated as 1), sets active_id, and enters PLAY.
  - The trigger output rises on the clock edge after the cycle in which the edge was detected. Latency is 2 clk from the req_* rising edge to the trigger.
- State PLAY:
  - Exactly one trigger, the one matching active_id, is high.
  - Each frame_tick decrements counter. A frame_tick in the grant cycle is not counted.
  - When frame_tick arrives with counter==1: if GAP_FRAMES>0, enter GAP with counter=GAP_FRAMES; otherwise enter IDLE. Either way active_id=0 and triggers drop on that edge.
  - Preemption: if a pending id is higher than active_id, it is granted immediately (PLAY→PLAY). The counter is reloaded, the old trigger drops and the new one rises on the same edge, dropped pulses for 1 cycle, and the old sound is not re-queued.
  - Retrigger: an edge of the currently active id reloads counter with the full duration. Its pending bit is not set and dropped is not pulsed.
  - A lower-priority pending id waits in pending.
- State GAP:
  - All triggers are low; busy=1.
  - Each frame_tick decrements counter. At counter==1 with a tick, enter IDLE.
  - A pending die request in GAP is granted immediately (PLAY). Others wait.
- mute=1 in any state: next edge → IDLE; pending cleared; triggers, active_id and busy go to 0. No dropped pulse.
- Simultaneous edges: all set pending. The highest is granted; the others remain pending and play later in priority order.
- A frame_tick coinciding with a preemption or retrigger is ignored (the reload wins).
- Counter arithmetic is unsigned CNT_W bits and never decrements below 1 in PLAY/GAP (no wrap).

Decomposition:
- Shared package:
  - SFX_NONE/EAT/HIT/DIE 2-bit id constants.
  - State encoding IDLE/PLAY/GAP.
  - Default frame durations, so that the APU_trigger replacement and the test bench agree.
- One natural sub-module, sfx_req_latch: edge detect plus pending bit with set/clear/flush, instantiated ×3.
- The priority encoder and FSM stay in the top.

Test Plan:
- Reset, then a one-cycle req_eat pulse → saw_trigger rises 2 clk later; active_id=01. After 8 frame_ticks saw_trigger falls and busy stays high for 2 more ticks, then 0.
- req_eat playing, req_die pulse after 3 ticks → on one edge saw_trigger=0, noise_trigger=1, dropped=1 for 1 cycle, active_id=11. Noise lasts 30 ticks; eat never resumes.
- req_hit and req_eat rise in the same cycle → square plays 6 ticks, then 2-tick gap, then saw plays 8 ticks; pending=0 at the end.
- req_hit held high 100 cycles, retriggered after 4 ticks (low, then high again) → only one grant at the first edge. The second edge reloads the counter, so square lasts 4+6=10 ticks total, with dropped=0 throughout.
- mute asserted mid-PLAY with eat pending → next edge all triggers 0, busy=0, pending=0. req_die edges during mute produce no grant. After mute falls, a fresh req_die edge is granted.
- rst_n pulled low mid-PLAY (asynchronously, between clock edges) → outputs 0 immediately, without waiting for clk. After release, frame_ticks alone cause no grant.
